// File: rtl/ram_pkg.sv
// Shared types and defaults for the simple dual-port RAM with power-on/clear sweep.
package ram_pkg;

  localparam int DATA_W_DEF = 14;
  localparam int ADDR_W_DEF = 12;

  // Legal read latencies are 1..RD_LAT_MAX; any larger value behaves as RD_LAT_MAX.
  localparam int RD_LAT_MAX = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/ram_clr_ctrl.sv
// Clear sweep controller: walks every address once after reset or a clr pulse,
// asserting busy and a write strobe that the top muxes onto the write port.
module ram_clr_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output clr_state_e        state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        // Leaving on the last address keeps the sweep to exactly one pass.
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy     = (state_q == CLEAR);
  assign clr_we   = (state_q == CLEAR);
  assign clr_addr = cnt_q;
  assign state    = state_q;

endmodule

// File: rtl/ram_sdp.sv
// Simple dual-port RAM (one write port, one read port) with registered read data,
// configurable read latency and read-during-write policy, and a zeroing sweep.
module ram_sdp
  import ram_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int RD_LAT   = 1,
  parameter bit WR_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              busy,
  input  logic              wren,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rden,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q,
  output logic              q_valid
);

  localparam int DEPTH     = 2 ** ADDR_W;
  localparam bit TWO_STAGE = (RD_LAT >= RD_LAT_MAX);

  logic              busy_w;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  clr_state_e        clr_state;

  ram_clr_ctrl #(.ADDR_W(ADDR_W)) u_clr_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .busy     (busy_w),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .state    (clr_state)
  );

  assign busy = busy_w;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_acc;
  logic              rd_acc;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_word;

  // User traffic is only accepted while idle; the sweep owns the write port otherwise.
  always_comb begin
    wr_acc    = wren & (clr_state == IDLE);
    rd_acc    = rden & (clr_state == IDLE);
    mem_we    = clr_we | wr_acc;
    mem_waddr = clr_we ? clr_addr : waddr;
    mem_wdata = clr_we ? '0 : wdata;
    rd_word   = mem[raddr];
    if (WR_FIRST && wr_acc && (waddr == raddr)) begin
      rd_word = wdata;
    end
  end

  // No reset on the array: contents are defined only by writes and the sweep.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic              q_valid_q, q_valid_d;
  logic [DATA_W-1:0] q_q, q_d;

  always_comb begin
    s1_valid_d = rd_acc;
    s1_data_d  = rd_acc ? rd_word : s1_data_q;
    if (TWO_STAGE) begin
      q_valid_d = s1_valid_q;
      q_d       = s1_valid_q ? s1_data_q : q_q;
    end else begin
      q_valid_d = rd_acc;
      q_d       = rd_acc ? rd_word : q_q;
    end
  end

  // In-flight reads keep draining through these stages even once a sweep starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      q_valid_q  <= 1'b0;
      q_q        <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      q_valid_q  <= q_valid_d;
      q_q        <= q_d;
    end
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;

endmodule
